mac_accumulator: RTL and testbench



---
 rtl/mac_accumulator.sv | 105 ++++++++++
 tb/tb_mac_accumulator.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Accumulation stage of the 16-bit MAC: sums a burst of LEN products into a
// 24-bit register under valid/ready. Optional saturation: define MAC_ACC_SAT_EN.

module adder_24bit #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             co
);
  assign {co, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

module mac_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   count;
  logic [ACC_W-1:0]   add_sum;
  logic [ACC_W-1:0]   acc_nxt;
  logic               add_co;
  logic               hs;

  adder_24bit #(.WIDTH(ACC_W)) u_add (
    .a   (acc_out),
    .b   ({{(ACC_W-PROD_W){1'b0}}, product}),
    .cin (1'b0),
    .sum (add_sum),
    .co  (add_co)
  );

`ifdef MAC_ACC_SAT_EN
  // Once pinned at all-ones, any further non-zero add carries out again.
  assign acc_nxt = add_co ? {ACC_W{1'b1}} : add_sum;
`else
  assign acc_nxt = add_sum;
`endif

  assign hs = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (start) state_nxt = (len != '0) ? ACCUM : DONE;
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && count == LEN_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out  <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc_out  <= '0;
          overflow <= 1'b0;
          if (len != '0) count <= len;
        end
        ACCUM: if (hs) begin
          acc_out  <= acc_nxt;
          overflow <= overflow | add_co;
          count    <= count - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator (LEN_W=9 build); expected sums are pushed
// to a queue at stimulus time and popped by a monitor on each output handshake.

module tb_mac_accumulator;
  localparam int PROD_W = 16;
  localparam int ACC_W  = 24;
  localparam int LEN_W  = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PROD_W-1:0] product = '0;
  logic [ACC_W-1:0]  acc_out;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              overflow;
  logic              busy;

  int total = 0;
  int bad   = 0;

  typedef struct { string name; logic [ACC_W-1:0] acc; logic ovf; } exp_t;
  exp_t sb[$];

  mac_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .product(product),
    .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare the result on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result: got acc=0x%0h with empty queue", acc_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_acc"}, 32'(acc_out), 32'(e.acc));
        chk({e.name, "_ovf"}, 32'(overflow), 32'(e.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] l);
    start = 1'b1; len = l;
    tick();
    start = 1'b0; len = '0;
  endtask

  // Present a product and return just after the edge on which it was accepted.
  task automatic send(input logic [PROD_W-1:0] p);
    bit got = 0;
    in_valid = 1'b1; product = p;
    for (int k = 0; k < 50 && !got; k++) begin
      if (in_ready) got = 1;
      tick();
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready never high, expected 1");
    end
  endtask

  task automatic idle_in(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // Wait for out_valid, hold out_ready low for 'hold' cycles checking stability,
  // then take the result and confirm return to IDLE.
  task automatic take(input string name, input int hold, input logic [ACC_W-1:0] stable_acc);
    bit got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      if (out_valid) got = 1; else tick();
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL %s_out_valid_timeout: out_valid 0 expected 1", name);
      return;
    end
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({name, "_hold_acc"}, 32'(acc_out), 32'(stable_acc));
      chk({name, "_hold_vld"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({name, "_idle_vld"}, 32'(out_valid), 32'd0);
  endtask

  task automatic push(input string name, input logic [ACC_W-1:0] a, input logic o);
    exp_t e;
    e.name = name; e.acc = a; e.ovf = o;
    sb.push_back(e);
  endtask

  initial begin
    // Reset: outputs must clear while rst_n is still low.
    #3;
    chk("rst_acc", 32'(acc_out), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #14 rst_n = 1'b1;
    tick(); tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic burst
    push("basic", 24'h000114, 1'b0);
    do_start(9'd3);
    chk("basic_in_ready", 32'(in_ready), 32'd1);
    chk("basic_busy", 32'(busy), 32'd1);
    send(16'h0005);
    chk("basic_acc1", 32'(acc_out), 32'h5);
    send(16'h0010);
    send(16'h00FF);
    in_valid = 1'b0;
    chk("basic_latency", 32'(out_valid), 32'd1);
    take("basic", 0, 24'h000114);

    // Stalls and backpressure
    push("stall", 24'h010000, 1'b0);
    do_start(9'd2);
    send(16'hFFFF);
    idle_in(4);
    chk("stall_gap_acc", 32'(acc_out), 32'h00FFFF);
    chk("stall_gap_rdy", 32'(in_ready), 32'd1);
    send(16'h0001);
    in_valid = 1'b0;
    chk("stall_latency", 32'(out_valid), 32'd1);
    take("stall", 5, 24'h010000);

    // Overflow over 257 products
`ifdef MAC_ACC_SAT_EN
    push("ovf", 24'hFFFFFF, 1'b1);
`else
    push("ovf", 24'h00FEFF, 1'b1);
`endif
    do_start(9'd257);
    for (int i = 0; i < 257; i++) send(16'hFFFF);
    in_valid = 1'b0;
    take("ovf", 0, '0);

    // Empty burst
    push("empty", 24'h000000, 1'b0);
    do_start(9'd0);
    chk("empty_done", 32'(out_valid), 32'd1);
    take("empty", 0, '0);

    // start ignored during ACCUM
    push("ign", 24'h000007, 1'b0);
    do_start(9'd2);
    send(16'h0003);
    in_valid = 1'b0;
    do_start(9'd5);
    chk("ign_acc", 32'(acc_out), 32'h3);
    chk("ign_state", 32'(in_ready), 32'd1);
    send(16'h0004);
    in_valid = 1'b0;
    chk("ign_done", 32'(out_valid), 32'd1);
    take("ign", 0, '0);

    // Reset mid-burst, partial burst discarded
    do_start(9'd4);
    send(16'h0011);
    send(16'h0022);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_acc", 32'(acc_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    push("after_rst", 24'h000007, 1'b0);
    do_start(9'd1);
    send(16'h0007);
    in_valid = 1'b0;
    take("after_rst", 0, '0);

    tick(); tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d results pending, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end
endmodule
